// File: rtl/axi_lite_master_if.sv
// AXI4-Lite AR/R/AW/W/B channel bundle between an initiator and a completer.
// Modports give each side its own signal directions.
interface axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one read or write in flight, 3 cycles to resp_valid
// with a zero-wait slave. Every output is registered or decoded from state; resp held until resp_ready.
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  axi_lite_master_if.master   axi
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    WR   = 3'd3,
    B    = 3'd4,
    RESP = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  // Handshakes are formed from registered state so no input reaches an output.
  logic req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  assign req_hs = (state_q == IDLE) && req_valid;
  assign ar_hs  = (state_q == AR) && axi.arready;
  assign r_hs   = (state_q == R) && axi.rvalid;
  assign aw_hs  = (state_q == WR) && !aw_done_q && axi.awready;
  assign w_hs   = (state_q == WR) && !w_done_q && axi.wready;
  assign b_hs   = (state_q == B) && axi.bvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_hs) state_d = req_wen ? WR : AR;
      AR:   if (ar_hs) state_d = R;
      R:    if (r_hs) state_d = RESP;
      WR:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = B;
      B:    if (b_hs) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (req_hs) begin
      addr_d    = req_addr;
      wdata_d   = req_wdata;
      wstrb_d   = req_wstrb;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
    if (aw_hs) aw_done_d = 1'b1;
    if (w_hs)  w_done_d  = 1'b1;
    if (r_hs) begin
      rdata_d = axi.rdata;
      err_d   = (axi.rresp != 2'b00);
    end
    if (b_hs) begin
      rdata_d = '0;
      err_d   = (axi.bresp != 2'b00);
    end
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    resp_valid  = (state_q == RESP);
    resp_rdata  = rdata_q;
    resp_err    = err_q;
    axi.arvalid = (state_q == AR);
    axi.araddr  = addr_q;
    axi.rready  = (state_q == R);
    axi.awvalid = (state_q == WR) && !aw_done_q;
    axi.awaddr  = addr_q;
    axi.wvalid  = (state_q == WR) && !w_done_q;
    axi.wdata   = wdata_q;
    axi.wstrb   = wstrb_q;
    axi.bready  = (state_q == B);
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: the bench plays both the core and the AXI slave.
module tb_axi_lite_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  axi_lite_master_if axi ();

  axi_lite_master dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = strb;
    chk("issue_req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("consume_resp_valid", resp_valid, 1'b0);
    chk("consume_req_ready", req_ready, 1'b1);
  endtask

  // Zero-wait read: arready on the first AR cycle, rvalid on the first R cycle.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] rd,
                         input logic [1:0] rr, input logic exp_err);
    issue(1'b0, addr, 32'h0, 4'h0);
    chk("rd_arvalid", axi.arvalid, 1'b1);
    chk("rd_araddr", axi.araddr, addr);
    chk("rd_req_ready_ar", req_ready, 1'b0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("rd_arvalid_drop", axi.arvalid, 1'b0);
    chk("rd_rready", axi.rready, 1'b1);
    chk("rd_req_ready_r", req_ready, 1'b0);
    axi.rvalid = 1'b1;
    axi.rdata  = rd;
    axi.rresp  = rr;
    tick();
    axi.rvalid = 1'b0;
    axi.rdata  = 32'h0;
    axi.rresp  = 2'b00;
    chk("rd_resp_valid", resp_valid, 1'b1);
    chk("rd_resp_rdata", resp_rdata, rd);
    chk("rd_resp_err", resp_err, exp_err);
    chk("rd_rready_drop", axi.rready, 1'b0);
    chk("rd_req_ready_resp", req_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    resp_ready = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    tick();
    tick();

    // Reset state
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_araddr", axi.araddr, 32'h0);
    chk("rst_awaddr", axi.awaddr, 32'h0);
    chk("rst_wdata", axi.wdata, 32'h0);
    chk("rst_wstrb", axi.wstrb, 4'h0);
    rst = 1'b1;
    tick();

    // Read, zero-wait slave
    do_read(32'h1000_0000, 32'hDEAD_BEEF, 2'b00, 1'b0);
    consume();

    // Write with AW and W accepted together, SLVERR response
    issue(1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'hF);
    chk("wr1_awvalid", axi.awvalid, 1'b1);
    chk("wr1_wvalid", axi.wvalid, 1'b1);
    chk("wr1_awaddr", axi.awaddr, 32'h2000_0010);
    chk("wr1_wdata", axi.wdata, 32'hCAFE_F00D);
    chk("wr1_wstrb", axi.wstrb, 4'hF);
    axi.awready = 1'b1; axi.wready = 1'b1;
    tick();
    axi.awready = 1'b0; axi.wready = 1'b0;
    chk("wr1_aw_w_drop", {axi.awvalid, axi.wvalid}, 2'b00);
    chk("wr1_bready", axi.bready, 1'b1);
    tick();
    chk("wr1_bready_wait", axi.bready, 1'b1);
    chk("wr1_no_resp_yet", resp_valid, 1'b0);
    axi.bvalid = 1'b1; axi.bresp = 2'b10;
    tick();
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    chk("wr1_resp_valid", resp_valid, 1'b1);
    chk("wr1_resp_err", resp_err, 1'b1);
    chk("wr1_resp_rdata", resp_rdata, 32'h0);
    chk("wr1_bready_drop", axi.bready, 1'b0);
    consume();

    // Write, wready immediate, awready after 3 cycles of awvalid
    issue(1'b1, 32'h1000_03F8, 32'h0000_0041, 4'h1);
    chk("wr2_awaddr", axi.awaddr, 32'h1000_03F8);
    chk("wr2_wdata", axi.wdata, 32'h0000_0041);
    chk("wr2_wstrb", axi.wstrb, 4'h1);
    chk("wr2_both_valid", {axi.awvalid, axi.wvalid}, 2'b11);
    axi.wready = 1'b1;
    tick();
    axi.wready = 1'b0;
    chk("wr2_c2_valids", {axi.awvalid, axi.wvalid}, 2'b10);
    chk("wr2_c2_bready", axi.bready, 1'b0);
    chk("wr2_c2_awaddr", axi.awaddr, 32'h1000_03F8);
    tick();
    chk("wr2_c3_valids", {axi.awvalid, axi.wvalid}, 2'b10);
    chk("wr2_c3_bready", axi.bready, 1'b0);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    chk("wr2_b_valids", {axi.awvalid, axi.wvalid}, 2'b00);
    chk("wr2_bready", axi.bready, 1'b1);
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    tick();
    axi.bvalid = 1'b0;
    chk("wr2_resp_valid", resp_valid, 1'b1);
    chk("wr2_resp_err", resp_err, 1'b0);
    chk("wr2_resp_rdata", resp_rdata, 32'h0);
    consume();

    // Backpressure: DECERR read held for 5 cycles with a new request pending
    do_read(32'h3000_0004, 32'h1234_5678, 2'b11, 1'b1);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h4000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_resp_valid", resp_valid, 1'b1);
      chk("bp_resp_rdata", resp_rdata, 32'h1234_5678);
      chk("bp_resp_err", resp_err, 1'b1);
      chk("bp_not_accepted", {req_ready, axi.arvalid}, 2'b00);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_idle_req_ready", req_ready, 1'b1);
    chk("bp_idle_no_ar", axi.arvalid, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("bp_accept_ar", axi.arvalid, 1'b1);
    chk("bp_accept_araddr", axi.araddr, 32'h4000_0000);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'h0BAD_F00D; axi.rresp = 2'b00;
    tick();
    axi.rvalid = 1'b0;
    chk("bp_second_rdata", resp_rdata, 32'h0BAD_F00D);
    chk("bp_second_err", resp_err, 1'b0);
    consume();

    // Reset in the middle of a read
    issue(1'b0, 32'h5000_0000, 32'h0, 4'h0);
    chk("mid_arvalid", axi.arvalid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_arvalid", axi.arvalid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_araddr", axi.araddr, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    do_read(32'h5000_0008, 32'hA5A5_5A5A, 2'b00, 1'b0);
    consume();

    // Spurious rvalid/bvalid while idle
    axi.rvalid = 1'b1; axi.rdata = 32'hFFFF_FFFF; axi.rresp = 2'b10;
    axi.bvalid = 1'b1; axi.bresp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_resp_valid", resp_valid, 1'b0);
      chk("spur_req_ready", req_ready, 1'b1);
      chk("spur_readies", {axi.rready, axi.bready}, 2'b00);
      chk("spur_rdata_kept", resp_rdata, 32'hA5A5_5A5A);
      chk("spur_err_kept", resp_err, 1'b0);
    end
    axi.rvalid = 1'b0; axi.bvalid = 1'b0; axi.rresp = 2'b00; axi.bresp = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
